// File: rtl/vx_bf16_norm_arbiter.sv
// Round-robin arbiter feeding a shared two-stage bf16 normalization pipeline.
// S0 holds the accepted request; S1 holds the normalized result and drives the outputs.
module vx_bf16_norm_arbiter #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned TAG_W    = $clog2(NUM_REQS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQS-1:0]    valid_in,
  output logic [NUM_REQS-1:0]    ready_in,
  input  logic [NUM_REQS*16-1:0] exp_in,
  input  logic [NUM_REQS*32-1:0] man_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [TAG_W-1:0]       tag_out,
  output logic [15:0]            norm_exp,
  output logic [31:0]            norm_man,
  output logic                   zero_out
);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] scan, win_idx;
  logic             win_found;
  logic             s1_adv, s0_can_load, xfer;
  logic [15:0]      sel_exp;
  logic [31:0]      sel_man;

  logic             s0_valid_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic [15:0]      s0_exp_q;
  logic [31:0]      s0_man_q;

  logic             s1_valid_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [15:0]      s1_exp_q;
  logic [31:0]      s1_man_q;
  logic             s1_zero_q;

  logic [4:0]       lead;
  logic [15:0]      n_exp;
  logic [31:0]      n_man;
  logic             n_zero;

  assign s1_adv      = !s1_valid_q || ready_out;
  assign s0_can_load = !s0_valid_q || s1_adv;

  // First valid requester scanning from ptr upward, wrapping modulo NUM_REQS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      scan = TAG_W'((32'(ptr_q) + k) % NUM_REQS);
      if (!win_found && valid_in[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  assign xfer = win_found && s0_can_load && !reset;

  always_comb begin
    ready_in = '0;
    if (xfer) ready_in[win_idx] = 1'b1;
    ptr_d = xfer ? TAG_W'((32'(win_idx) + 1) % NUM_REQS) : ptr_q;
  end

  always_comb begin
    sel_exp = '0;
    sel_man = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (win_idx == TAG_W'(i)) begin
        sel_exp = exp_in[16*i +: 16];
        sel_man = man_in[32*i +: 32];
      end
    end
  end

  // Leading-one detect and shift so the leading one lands at bit 7.
  always_comb begin
    lead = '0;
    for (int i = 0; i < 32; i++) begin
      if (s0_man_q[i]) lead = 5'(i);
    end
    n_zero = 1'b0;
    if (s0_man_q == 32'd0) begin
      n_man  = '0;
      n_exp  = s0_exp_q;
      n_zero = 1'b1;
    end else if (lead >= 5'd7) begin
      n_man = s0_man_q >> (lead - 5'd7);
      n_exp = s0_exp_q + 16'(lead - 5'd7);
    end else begin
      n_man = s0_man_q << (5'd7 - lead);
      n_exp = s0_exp_q - 16'(5'd7 - lead);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      s0_exp_q   <= '0;
      s0_man_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_zero_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (s0_can_load) s0_valid_q <= xfer;
      if (xfer) begin
        s0_tag_q <= win_idx;
        s0_exp_q <= sel_exp;
        s0_man_q <= sel_man;
      end
      // Fields only change when a new result is loaded, so a stalled output stays stable.
      if (s1_adv) begin
        s1_valid_q <= s0_valid_q;
        if (s0_valid_q) begin
          s1_tag_q  <= s0_tag_q;
          s1_exp_q  <= n_exp;
          s1_man_q  <= n_man;
          s1_zero_q <= n_zero;
        end
      end
    end
  end

  assign valid_out = s1_valid_q;
  assign tag_out   = s1_tag_q;
  assign norm_exp  = s1_exp_q;
  assign norm_man  = s1_man_q;
  assign zero_out  = s1_zero_q;

endmodule

// File: tb/tb_vx_bf16_norm_arbiter.sv
// Directed bench for vx_bf16_norm_arbiter: arbitration order, normalization, latency,
// backpressure and mid-operation reset.
module tb_vx_bf16_norm_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  valid_in;
  logic [N-1:0]  ready_in;
  logic [N*16-1:0] exp_in;
  logic [N*32-1:0] man_in;
  logic          valid_out;
  logic          ready_out;
  logic [1:0]    tag_out;
  logic [15:0]   norm_exp;
  logic [31:0]   norm_man;
  logic          zero_out;

  int vectors = 0;
  int miscompares = 0;

  vx_bf16_norm_arbiter #(.NUM_REQS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .exp_in    (exp_in),
    .man_in    (man_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .tag_out   (tag_out),
    .norm_exp  (norm_exp),
    .norm_man  (norm_man),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [15:0] e, input logic [31:0] m);
    exp_in[16*i +: 16] = e;
    man_in[32*i +: 32] = m;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    valid_in = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = '1; ready_out = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_out); end
    vectors++; if (tag_out !== 2'd0) begin miscompares++; $display("FAIL reset_tag got %0d want 0", tag_out); end
    vectors++; if (norm_exp !== 16'd0) begin miscompares++; $display("FAIL reset_exp got %h want 0", norm_exp); end
    vectors++; if (norm_man !== 32'd0) begin miscompares++; $display("FAIL reset_man got %h want 0", norm_man); end
    vectors++; if (zero_out !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b want 0", zero_out); end
    vectors++; if (ready_in !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", ready_in); end
    @(negedge clk);
    reset = 1'b0; valid_in = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(2, 16'h0000, 32'h0000_0100); valid_in = 4'b0100; #1;
    vectors++; if (ready_in !== 4'b0100) begin miscompares++; $display("FAIL single_ready got %b want 0100", ready_in); end
    @(negedge clk); valid_in = '0; #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_early got %b want 0", valid_out); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", valid_out); end
    vectors++; if (tag_out !== 2'd2) begin miscompares++; $display("FAIL single_tag got %0d want 2", tag_out); end
    vectors++; if (norm_man !== 32'h80) begin miscompares++; $display("FAIL single_man got %h want 80", norm_man); end
    vectors++; if (norm_exp !== 16'd1) begin miscompares++; $display("FAIL single_exp got %h want 0001", norm_exp); end
    vectors++; if (zero_out !== 1'b0) begin miscompares++; $display("FAIL single_zero got %b want 0", zero_out); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_dup got %b want 0", valid_out); end
  endtask

  task automatic test_normalize();
    logic [31:0] vm  [7] = '{32'h0000_0100, 32'h0000_0001, 32'h8000_0000, 32'h0,
                             32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_00C0};
    logic [15:0] ve  [7] = '{16'h0000, 16'h000A, 16'hFFFB, 16'h1234, 16'h7FFF, 16'h8000, 16'h0042};
    logic [31:0] wm  [7] = '{32'h80, 32'h80, 32'h80, 32'h0, 32'hFF, 32'hAA, 32'hC0};
    logic [15:0] we  [7] = '{16'h0001, 16'h0003, 16'h0013, 16'h1234, 16'h8017, 16'h7FFF, 16'h0042};
    logic        wz  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      set_req(v % N, ve[v], vm[v]);
      valid_in = '0; valid_in[v % N] = 1'b1;
      @(negedge clk); valid_in = '0;
      @(negedge clk); #1;
      vectors++; if (valid_out !== 1'b1 || tag_out !== 2'(v % N)) begin miscompares++;
        $display("FAIL norm%0d_tag got v=%b t=%0d want v=1 t=%0d", v, valid_out, tag_out, v % N); end
      vectors++; if (norm_man !== wm[v]) begin miscompares++; $display("FAIL norm%0d_man got %h want %h", v, norm_man, wm[v]); end
      vectors++; if (norm_exp !== we[v]) begin miscompares++; $display("FAIL norm%0d_exp got %h want %h", v, norm_exp, we[v]); end
      vectors++; if (zero_out !== wz[v]) begin miscompares++; $display("FAIL norm%0d_zero got %b want %b", v, zero_out, wz[v]); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    ready_out = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 16'(i * 16), 32'h80);
    valid_in = '1;
    for (int k = 0; k < 10; k++) begin
      #1;
      vectors++; if (ready_in !== 4'(1 << (k % N))) begin miscompares++;
        $display("FAIL rr_ready%0d got %b want %b", k, ready_in, 4'(1 << (k % N))); end
      if (k >= 2) begin
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL rr_gap%0d got %b want 1", k, valid_out); end
        vectors++; if (tag_out !== 2'((k - 2) % N)) begin miscompares++;
          $display("FAIL rr_tag%0d got %0d want %0d", k, tag_out, (k - 2) % N); end
        vectors++; if (norm_exp !== 16'(((k - 2) % N) * 16)) begin miscompares++;
          $display("FAIL rr_exp%0d got %h want %h", k, norm_exp, 16'(((k - 2) % N) * 16)); end
      end
      @(negedge clk);
    end
    valid_in = '0;
  endtask

  task automatic test_rr_skip();
    apply_reset();
    ready_out = 1'b1;
    set_req(1, 16'h0011, 32'h80); set_req(2, 16'h0022, 32'h80); set_req(3, 16'h0033, 32'h80);
    valid_in = 4'b0010; #1;
    vectors++; if (ready_in !== 4'b0010) begin miscompares++; $display("FAIL skip_seed got %b want 0010", ready_in); end
    @(negedge clk); valid_in = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    valid_in = 4'b1010; #1;
    vectors++; if (ready_in !== 4'b1000) begin miscompares++; $display("FAIL skip_first got %b want 1000", ready_in); end
    @(negedge clk); #1;
    vectors++; if (ready_in !== 4'b0010) begin miscompares++; $display("FAIL skip_second got %b want 0010", ready_in); end
    @(negedge clk); valid_in = '1; #1;
    vectors++; if (ready_in !== 4'b0100) begin miscompares++; $display("FAIL skip_ptr got %b want 0100", ready_in); end
    vectors++; if (valid_out !== 1'b1 || tag_out !== 2'd3) begin miscompares++;
      $display("FAIL skip_out3 got v=%b t=%0d want v=1 t=3", valid_out, tag_out); end
    @(negedge clk); valid_in = '0; #1;
    vectors++; if (tag_out !== 2'd1 || norm_exp !== 16'h0011) begin miscompares++;
      $display("FAIL skip_out1 got t=%0d e=%h want t=1 e=0011", tag_out, norm_exp); end
    @(negedge clk); #1;
    vectors++; if (tag_out !== 2'd2 || norm_exp !== 16'h0022) begin miscompares++;
      $display("FAIL skip_out2 got t=%0d e=%h want t=2 e=0022", tag_out, norm_exp); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL skip_drain got %b want 0", valid_out); end
  endtask

  task automatic test_stall();
    apply_reset();
    ready_out = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 16'(i * 16 + 1), 32'h80);
    valid_in = '1; #1;
    vectors++; if (ready_in !== 4'b0001 || valid_out !== 1'b0) begin miscompares++;
      $display("FAIL stall_c0 got r=%b v=%b want r=0001 v=0", ready_in, valid_out); end
    @(negedge clk); #1;
    vectors++; if (ready_in !== 4'b0010) begin miscompares++; $display("FAIL stall_c1 got %b want 0010", ready_in); end
    for (int c = 2; c < 5; c++) begin
      @(negedge clk); #1;
      vectors++; if (ready_in !== 4'b0000) begin miscompares++; $display("FAIL stall_ready%0d got %b want 0000", c, ready_in); end
      vectors++; if (valid_out !== 1'b1 || tag_out !== 2'd0 || norm_exp !== 16'h0001 || norm_man !== 32'h80) begin
        miscompares++;
        $display("FAIL stall_hold%0d got v=%b t=%0d e=%h m=%h want v=1 t=0 e=0001 m=80",
                 c, valid_out, tag_out, norm_exp, norm_man);
      end
    end
    @(negedge clk); ready_out = 1'b1; #1;
    vectors++; if (ready_in !== 4'b0100) begin miscompares++; $display("FAIL stall_release got %b want 0100", ready_in); end
    vectors++; if (tag_out !== 2'd0) begin miscompares++; $display("FAIL stall_out0 got %0d want 0", tag_out); end
    @(negedge clk); valid_in = '0; #1;
    vectors++; if (valid_out !== 1'b1 || tag_out !== 2'd1 || norm_exp !== 16'h0011) begin miscompares++;
      $display("FAIL stall_out1 got v=%b t=%0d e=%h want v=1 t=1 e=0011", valid_out, tag_out, norm_exp); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b1 || tag_out !== 2'd2 || norm_exp !== 16'h0021) begin miscompares++;
      $display("FAIL stall_out2 got v=%b t=%0d e=%h want v=1 t=2 e=0021", valid_out, tag_out, norm_exp); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b want 0", valid_out); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ready_out = 1'b0;
    set_req(0, 16'h0100, 32'h0000_0001);
    for (int i = 1; i < N; i++) set_req(i, 16'h0700, 32'h0000_0300);
    valid_in = '1;
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    vectors++; if (ready_in !== 4'b0000) begin miscompares++; $display("FAIL rmid_ready got %b want 0000", ready_in); end
    @(negedge clk); reset = 1'b0; ready_out = 1'b1; #1;
    vectors++; if (valid_out !== 1'b0 || tag_out !== 2'd0 || norm_exp !== 16'd0 || norm_man !== 32'd0 || zero_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_clear got v=%b t=%0d e=%h m=%h z=%b want all 0",
               valid_out, tag_out, norm_exp, norm_man, zero_out);
    end
    vectors++; if (ready_in !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr got %b want 0001", ready_in); end
    @(negedge clk); valid_in = '0; #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rmid_stale got %b want 0", valid_out); end
    @(negedge clk); #1;
    vectors++; if (valid_out !== 1'b1 || tag_out !== 2'd0 || norm_exp !== 16'h00F9 || norm_man !== 32'h80) begin
      miscompares++;
      $display("FAIL rmid_first got v=%b t=%0d e=%h m=%h want v=1 t=0 e=00f9 m=80",
               valid_out, tag_out, norm_exp, norm_man);
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = '0; ready_out = 1'b1; exp_in = '0; man_in = '0;
    test_reset();
    test_single();
    test_normalize();
    test_round_robin();
    test_rr_skip();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_bf16_norm_arbiter.md
# vx_bf16_norm_arbiter

Shares one bf16 mantissa/exponent normalization datapath among NUM_REQS requesters (e.g. per-lane FMA/add result ports) using round-robin arbitration. The accepted request is registered, normalized and registered again, so the result appears 2 cycles later with the winner's index as a tag. The block sits between the bf16 arithmetic cores and the rounding/packing stage. Full valid/ready backpressure; one result per cycle when unstalled.

## Interface
- NUM_REQS, 4, number of requesters (2..16)
- TAG_W, $clog2(NUM_REQS), width of the requester-index tag (derived; do not override)
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  NUM_REQS  per-requester request valid
- ready_in  output  NUM_REQS  per-requester accept; at most one bit set per cycle
- exp_in  input  NUM_REQS*16  signed unnormalized exponents; requester i uses bits [16i+15:16i]
- man_in  input  NUM_REQS*32  unnormalized mantissas; requester i uses bits [32i+31:32i]
- valid_out  output  1  result valid
- ready_out  input  1  consumer accept
- tag_out  output  TAG_W  index of the requester that produced the result
- norm_exp  output  16  signed normalized exponent
- norm_man  output  32  normalized mantissa, leading one at bit 7
- zero_out  output  1  input mantissa was zero

## Operation
- Arbiter: round-robin with priority pointer `ptr` (TAG_W bits). Winner = first i with valid_in[i] set, scanning ptr, ptr+1, …, wrapping modulo NUM_REQS.
- ready_in[winner] = 1 only when stage S0 can load (S0 empty, or S0 advances this cycle); all other ready_in bits are 0. ready_in must not depend on ready_in itself; it may depend combinationally on valid_in and ready_out.
- Transfer on requester i = valid_in[i] & ready_in[i]. On transfer, ptr <= (winner+1) mod NUM_REQS; otherwise ptr is held. A requester whose valid stays high is served within NUM_REQS transfers.
- S0 register: valid, tag, exp, man of the accepted request.
- Normalize (combinational, between S0 and S1): p = position of the highest set bit of man (0..31).
  - man == 0: norm_man = 0, norm_exp = exp, zero = 1.
  - p >= 7: norm_man = man >> (p-7), norm_exp = exp + (p-7).
  - p < 7: norm_man = man << (7-p), norm_exp = exp - (7-p).
  - Exponent arithmetic is 16-bit two's complement, wraps without saturation; discarded right-shift bits are dropped (rounding is downstream).
- S1 register drives valid_out, tag_out, norm_exp, norm_man, zero_out directly (no combinational output path).
- Pipeline advance: S1 loads when S1 is empty or ready_out is 1; S0 advances into S1 under the same condition; S0 loads under the ready_in rule above. Bubbles collapse: an empty stage always accepts.
- Output fields are held stable while valid_out=1 and ready_out=0.

## Timing
- Reset (synchronous, active-high, cycle-level): valid_out=0, tag_out=0, norm_exp=0, norm_man=0, zero_out=0, S0 valid=0, ptr=0. ready_in is 0 during reset cycles.
- Reset mid-operation discards both stages' contents; no result is emitted for them; ptr returns to 0.
- Latency: transfer at edge N, valid_out high after edge N+2 (visible in cycle N+2).
- Throughput: 1 transfer/cycle with ready_out held high.
- Full stall: S0 and S1 valid, ready_out=0 -> all ready_in=0 and no state changes except ptr is held.
- Simultaneous pop and push: with S1 full, S0 full and ready_out=1, S1 takes S0, S0 takes a new request in the same cycle.
- valid_in dropping without a transfer is legal; ptr is unchanged.

## Test plan
- Single requester 2, exp=0, man=0x0000_0100 -> tag_out=2, norm_man=0x80, norm_exp=1, zero_out=0, valid_out exactly 2 cycles after the transfer.
- man=0x0000_0001, exp=10 -> norm_man=0x80, norm_exp=3; man=0x8000_0000, exp=-5 -> norm_man=0x80, norm_exp=19; man=0 -> zero_out=1, norm_exp unchanged.
- All 4 requesters valid continuously, ready_out=1 -> tags 0,1,2,3,0,… with one result per cycle, no gaps after the first.
- Requesters 1 and 3 valid, ptr=2 -> 3 granted first, then 1; ptr ends at 2.
- Hold ready_out=0 for 5 cycles while requests pend -> after 2 transfers all ready_in=0, outputs stable; release -> results in order, none lost or duplicated.
- Assert reset for 1 cycle with both stages full -> next cycle valid_out=0, ptr=0, outputs zero; first post-reset request from requester 0 has normal latency.
